// File: rtl/grf_pkg.sv
// Shared constants and state encoding for the general register file and
// its sequential read-out engine.
package grf_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } scan_state_e;

  // A write makes the dump stale when it lands on a register that has
  // already been captured (address at or below the scan pointer). The
  // register at the pointer counts as captured even on its capture edge,
  // because the GRF write and the capture sample on the same edge and the
  // capture sees the old value. Register 0 is hard-wired and never stale.
  function automatic logic hits_captured(input logic          en,
                                         input logic [AW-1:0] addr,
                                         input logic [AW-1:0] ptr);
    logic hit;
    if (en && (addr != {AW{1'b0}}) && (addr <= ptr)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
    return hit;
  endfunction

endpackage

// File: rtl/grf_scan_reader.sv
// Sequential GRF dump engine: walks addresses 0..NREG-1 through one read
// port, streams (address, data) beats over valid/ready and flags the dump
// stale when a captured register is overwritten mid-scan.
module grf_scan_reader
  import grf_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          done,
  output logic          stale
);

  scan_state_e   state_r;
  logic [AW-1:0] ptr_r;
  logic          stale_hit_s;

  // The read port address is the scan pointer register itself.
  assign rd_addr = ptr_r;

  // Decode whether this cycle's GRF write lands on an already-captured register.
  always_comb begin
    stale_hit_s = hits_captured(wr_en, wr_addr, ptr_r);
  end

  // Scan FSM with pointer, capture register and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      ptr_r     <= {AW{1'b0}};
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= {AW{1'b0}};
      out_data  <= {DW{1'b0}};
      done      <= 1'b0;
      stale     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            ptr_r   <= {AW{1'b0}};
            stale   <= 1'b0;
            busy    <= 1'b1;
            state_r <= READ;
          end else begin
            state_r <= IDLE;
          end
        end

        READ: begin
          // Capture the combinational GRF read for the current pointer.
          out_data  <= rd_data;
          out_addr  <= ptr_r;
          out_valid <= 1'b1;
          state_r   <= SEND;
          if (stale_hit_s) begin
            stale <= 1'b1;
          end else begin
            stale <= stale;
          end
        end

        SEND: begin
          if (stale_hit_s) begin
            stale <= 1'b1;
          end else begin
            stale <= stale;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            if (ptr_r == LAST_ADDR) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              ptr_r   <= ptr_r + {{(AW-1){1'b0}}, 1'b1};
              state_r <= READ;
            end
          end else begin
            state_r <= SEND;
          end
        end

        DONE: begin
          // Single-cycle pulse; start is ignored here and stale is kept.
          done    <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grf_scan_reader.sv
// Directed self-checking bench for grf_scan_reader with a behavioural GRF
// and an expected-beat scoreboard.
module tb_grf_scan_reader;
  import grf_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          done;
  logic          stale;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] grf [NREG];
  logic [AW-1:0] exp_addr_q [$];
  logic [DW-1:0] exp_data_q [$];
  logic [DW-1:0] seen_data [NREG];
  logic          mon_en = 1'b1;

  logic          prev_valid = 1'b0;
  logic          prev_hs    = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [DW-1:0] prev_data  = '0;

  grf_scan_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .done      (done),
    .stale     (stale)
  );

  always #5 clk = ~clk;

  // Behavioural GRF: combinational read, register 0 hard-wired to zero.
  assign rd_data = (rd_addr == '0) ? '0 : grf[rd_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en && wr_addr != '0) grf[wr_addr] <= wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] preload_val(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'h1000_0000 + i;
  endfunction

  // Compare process: every handshake against the scoreboard, hold rules otherwise.
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_addr", out_addr, prev_addr);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got addr %0d with no beat expected", out_addr);
        end else begin
          chk("beat_addr", out_addr, exp_addr_q[0]);
          chk("beat_data", out_data, exp_data_q[0]);
          seen_data[out_addr] = out_data;
          void'(exp_addr_q.pop_front());
          void'(exp_data_q.pop_front());
        end
      end
      if (done) chk("done_all_beats", exp_addr_q.size(), 0);
      prev_valid <= out_valid;
      prev_hs    <= out_valid && out_ready;
      prev_addr  <= out_addr;
      prev_data  <= out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    for (int i = 1; i < NREG; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = preload_val(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic fill_exp();
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < NREG; i++) begin
      exp_addr_q.push_back(AW'(i));
      exp_data_q.push_back(preload_val(i));
      seen_data[i] = 32'hxxxx_xxxx;
    end
  endtask

  // One scan; optionally a single GRF write triggered when beat 'trig' is
  // presented (at_capture: on the capture edge of register trig+1 instead).
  task automatic run_scan(input bit toggle, input bit hold_start, input int trig,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input bit at_capture, input logic exp_stale, input bit check_lat);
    int  cyc_e;
    int  k;
    bit  got_done;
    bit  wrote;
    bit  pending;
    start = 1'b1;
    tick();
    cyc_e = cyc;
    if (!hold_start) start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("no_valid_in_read", out_valid, 1'b0);
    chk("stale_cleared", stale, 1'b0);
    chk("first_rd_addr", rd_addr, 5'd0);
    got_done = 1'b0;
    wrote    = 1'b0;
    pending  = 1'b0;
    k        = 0;
    while (!got_done && k < 400) begin
      out_ready = toggle ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      wr_en     = 1'b0;
      if (pending) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd; pending = 1'b0;
      end else if (trig >= 0 && !wrote && out_valid && out_addr == AW'(trig) &&
                   (!at_capture || out_ready)) begin
        wrote = 1'b1;
        if (at_capture) pending = 1'b1;
        else begin
          wr_en = 1'b1; wr_addr = wa; wr_data = wd;
        end
      end
      tick();
      k++;
      if (k == 1) begin
        chk("first_valid", out_valid, 1'b1);
        chk("first_addr", out_addr, 5'd0);
      end
      if (done) got_done = 1'b1;
    end
    wr_en     = 1'b0;
    out_ready = 1'b1;
    if (!got_done) begin
      total++;
      bad++;
      $display("FAIL scan_timeout: no done after %0d cycles", k);
    end
    if (check_lat) chk("done_cycle", cyc - cyc_e + 1, 65);
    chk("stale_at_done", stale, exp_stale);
    chk("busy_in_done", busy, 1'b0);
    tick();
    start = 1'b0;
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    chk("stale_sticky", stale, exp_stale);
    tick();
    chk("still_idle", busy, 1'b0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NREG; i++) grf[i] = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_addr", out_addr, 5'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_done", done, 1'b0);
    chk("rst_stale", stale, 1'b0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    tick();
    reset = 1'b0;
    preload();

    // Full scan, out_ready tied high.
    fill_exp();
    run_scan(1'b0, 1'b0, -1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("lit_beat0", seen_data[0], 32'h0000_0000);
    chk("lit_beat31", seen_data[31], 32'h1000_001F);
    chk("lit_beat7", seen_data[7], 32'h1000_0007);

    // Back-pressure 1-0-0-1.
    fill_exp();
    run_scan(1'b1, 1'b0, -1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Overwrite an already-captured register: old value kept, stale set.
    fill_exp();
    run_scan(1'b0, 1'b0, 10, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1);
    chk("lit_beat3_old", seen_data[3], 32'h1000_0003);
    preload();

    // Overwrite a register not yet captured: new value shows, no stale.
    fill_exp();
    exp_data_q[20] = 32'hDEAD_BEEF;
    run_scan(1'b0, 1'b0, 10, 5'd20, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    chk("lit_beat20_new", seen_data[20], 32'hDEAD_BEEF);
    preload();

    // Write landing on the capture edge of register 5: old value, stale.
    fill_exp();
    run_scan(1'b0, 1'b0, 4, 5'd5, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b1);
    chk("lit_beat5_old", seen_data[5], 32'h1000_0005);
    preload();

    // Writes to register 0 never mark the dump stale.
    fill_exp();
    run_scan(1'b0, 1'b0, 10, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
    chk("lit_beat0_zero", seen_data[0], 32'h0000_0000);

    // Reset in SEND with ptr=15 aborts the scan without a done pulse.
    fill_exp();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_addr == 5'd15) && n < 200) begin
      tick();
      n++;
    end
    chk("reached_ptr15", out_addr, 5'd15);
    mon_en    = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_addr", out_addr, 5'd0);
    chk("abort_data", out_data, 32'h0);
    chk("abort_rd_addr", rd_addr, 5'd0);
    chk("abort_stale", stale, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", done, 1'b0);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    fill_exp();
    run_scan(1'b0, 1'b0, -1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);

    // start held high through a whole scan: exactly one scan, ignored in DONE.
    fill_exp();
    run_scan(1'b0, 1'b1, -1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("hold_start_no_extra", exp_addr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grf_scan_reader.md
# grf_scan_reader

Sequential read-out engine for the general register file: on a start pulse it walks register addresses 0..NREG-1 through one GRF read port and streams each (address, data) pair over a valid/ready handshake. It sits beside the GRF in the mips top level, acting as the reader for the writeback path that writes the file, and gives the bench and debug logic a full register dump without stalling the core. It also watches the GRF write strobe and flags the dump as stale if an already-captured register is overwritten mid-scan.

## Interface
- NREG, 32, number of registers scanned (addresses 0..NREG-1)
- AW, 5, register address width
- DW, 32, register data width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  scan request, sampled only in IDLE
- busy  out  1  high in READ and SEND
- rd_addr  out  AW  address to GRF read port (rs or rt input)
- rd_data  in  DW  GRF combinational read data for rd_addr (register 0 reads 0)
- wr_en  in  1  GRF write strobe (RFWr)
- wr_addr  in  AW  GRF write address (RegAddr)
- out_valid  out  1  out_addr/out_data hold a captured register
- out_ready  in  1  consumer accepts when high with out_valid
- out_addr  out  AW  address of the emitted register
- out_data  out  DW  captured register value
- done  out  1  one-cycle pulse after the last register is accepted
- stale  out  1  an already-captured register was written during the scan

## Operation
- States: IDLE, READ, SEND, DONE. Pointer ptr (AW bits) drives rd_addr directly.
- IDLE: start=1 -> ptr<=0, stale<=0, go READ. start=0 -> stay.
- READ: rd_addr=ptr; at the edge, out_data<=rd_data, out_addr<=ptr, out_valid<=1, go SEND.
- SEND: out_valid, out_addr, out_data held stable until out_ready=1. On handshake: if ptr==NREG-1 -> out_valid<=0, go DONE; else ptr<=ptr+1, out_valid<=0, go READ.
- DONE: done=1 for exactly this cycle, go IDLE. stale keeps its value until the next accepted start.
- start while busy or in DONE: ignored, no queueing.
- Stale detection while busy: wr_en=1 and wr_addr!=0 and wr_addr<=ptr sets stale (sticky). Covers a write landing on the same edge the READ capture samples (captured value is the old one). Writes to address 0 never set stale.
- ptr increment never wraps inside a scan; next scan restarts at 0.

## Timing
- Reset (async, any state): state=IDLE, ptr=0, rd_addr=0, busy=0, out_valid=0, out_addr=0, out_data=0, done=0, stale=0. Mid-scan reset aborts with no done pulse.
- start high at edge E in IDLE: READ in cycle E+1, first out_valid in cycle E+2.
- Per register: 1 READ cycle + >=1 SEND cycle. With out_ready tied high, full scan = 2*NREG cycles, done in cycle 2*NREG+1 after the start edge; next start accepted in the cycle after done.
- out_valid never drops without a handshake; out_data/out_addr never change while out_valid=1.
- Back-pressure has no timeout; the GRF stays writable throughout.

## Structure
- Shared package grf_pkg: NREG, AW, DW constants and state encoding (IDLE=2'd0, READ=2'd1, SEND=2'd2, DONE=2'd3), reused by GRF and bench.
- Single module; no sub-module is natural (FSM, pointer, capture register and stale comparator are small).

## Test plan
- Reset then preload GRF $1..$31 with 32'h1000_0000+i, start pulse, out_ready=1 -> 32 beats, beat i = (i, 32'h1000_0000+i), beat 0 = (0, 0); done in cycle 65 after start edge; stale=0.
- Same preload, out_ready toggling 1-0-0-1 -> same 32 beats in order, out_addr/out_data stable while out_ready=0, no beat lost or duplicated.
- During scan, write $3<=32'hDEAD_BEEF when ptr=10 -> beat 3 shows old value, stale=1 at done; write $20 when ptr=10 -> beat 20 shows 32'hDEAD_BEEF, stale=0.
- Write to $0 with wr_en=1 mid-scan -> stale stays 0, beat 0 data 0.
- Assert reset while ptr=15 in SEND -> all outputs to reset values immediately, no done; new start restarts at address 0.
- start held high through whole scan -> exactly one scan runs, next begins only after done.
